// File: rtl/dds_pkg.sv
// Shared widths and sweep state encoding for the DDS control/waveform blocks.
package dds_pkg;

  localparam int unsigned DDS_KW = 32;
  localparam int unsigned DDS_PW = 11;
  localparam int unsigned DDS_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DWELL,
    ST_STEP,
    ST_TURN,
    ST_FIN
  } sweep_state_t;

endpackage

// File: rtl/dds_sweep_step.sv
// Combinational tuning-word step: K +/- step, clamped to the target word on
// overshoot or on carry/borrow out of the KW-bit range.
module dds_sweep_step #(
  parameter int unsigned KW = 32
) (
  input  logic [KW-1:0] k,
  input  logic [KW-1:0] step,
  input  logic [KW-1:0] target,
  input  logic          down,
  output logic [KW-1:0] k_next
);

  logic [KW:0] sum;
  logic [KW:0] diff;

  always_comb begin
    sum  = {1'b0, k} + {1'b0, step};
    diff = {1'b0, k} - {1'b0, step};
    if (down) begin
      k_next = (diff[KW] || (diff[KW-1:0] <= target)) ? target : diff[KW-1:0];
    end else begin
      k_next = (sum[KW] || (sum[KW-1:0] >= target)) ? target : sum[KW-1:0];
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep controller feeding dds_wave with K and P.
// Optional triangle (up-then-down) sweeps are built when DDS_SWEEP_TRIANGLE_EN is defined.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned KW = DDS_KW,
  parameter int unsigned PW = DDS_PW,
  parameter int unsigned DW = DDS_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [KW-1:0] cfg_k_start,
  input  logic [KW-1:0] cfg_k_stop,
  input  logic [KW-1:0] cfg_k_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [PW-1:0] cfg_phase,
  input  logic          cfg_tri,
  input  logic          abort,
  output logic [KW-1:0] K,
  output logic [PW-1:0] P,
  output logic          busy,
  output logic          done
);

  sweep_state_t  state_q, state_d;
  sweep_state_t  ev;
  logic [KW-1:0] k_q, k_d;
  logic [PW-1:0] p_q, p_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [KW-1:0] step_q, step_d;
  logic [KW-1:0] target_q, target_d;
  logic          down_q, down_d;
  logic          ready_q, ready_d;
  logic          turn_ok;
  logic [KW-1:0] step_target;
  logic          step_down;
  logic [KW-1:0] k_next;

`ifdef DDS_SWEEP_TRIANGLE_EN
  logic [KW-1:0] start_q, start_d;
  logic          tri_q, tri_d;
  logic          leg2_q, leg2_d;

  assign turn_ok = tri_q && !leg2_q && (step_q != '0) && (start_q != target_q);
`else
  logic unused_tri;

  assign unused_tri = cfg_tri;
  assign turn_ok    = 1'b0;
`endif

  // STEP and TURN are decided in the final dwell cycle and take effect on the
  // same edge, so they never occupy a cycle of their own in state_q.
  always_comb begin
    ev          = ST_DWELL;
    step_target = target_q;
    step_down   = down_q;
    if (cnt_q == '0) begin
      if ((k_q == target_q) || (step_q == '0)) begin
        ev = turn_ok ? ST_TURN : ST_FIN;
      end else begin
        ev = ST_STEP;
      end
    end
`ifdef DDS_SWEEP_TRIANGLE_EN
    if (ev == ST_TURN) begin
      step_target = start_q;
      step_down   = ~down_q;
    end
`endif
  end

  dds_sweep_step #(
    .KW(KW)
  ) u_step (
    .k      (k_q),
    .step   (step_q),
    .target (step_target),
    .down   (step_down),
    .k_next (k_next)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    step_d   = step_q;
    target_d = target_q;
    down_d   = down_q;
`ifdef DDS_SWEEP_TRIANGLE_EN
    start_d  = start_q;
    tri_d    = tri_q;
    leg2_d   = leg2_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          state_d  = ST_DWELL;
          k_d      = cfg_k_start;
          p_d      = cfg_phase;
          cnt_d    = cfg_dwell;
          dwell_d  = cfg_dwell;
          step_d   = cfg_k_step;
          target_d = cfg_k_stop;
          down_d   = (cfg_k_start > cfg_k_stop);
`ifdef DDS_SWEEP_TRIANGLE_EN
          start_d  = cfg_k_start;
          tri_d    = cfg_tri;
          leg2_d   = 1'b0;
`endif
        end
      end
      ST_DWELL: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ev == ST_DWELL) begin
          cnt_d = cnt_q - 1'b1;
        end else if (ev == ST_FIN) begin
          state_d = ST_FIN;
        end else begin
          k_d   = k_next;
          cnt_d = dwell_q;
`ifdef DDS_SWEEP_TRIANGLE_EN
          if (ev == ST_TURN) begin
            target_d = start_q;
            down_d   = ~down_q;
            leg2_d   = 1'b1;
          end
`endif
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      dwell_q  <= '0;
      step_q   <= '0;
      target_q <= '0;
      down_q   <= 1'b0;
      ready_q  <= 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
      start_q  <= '0;
      tri_q    <= 1'b0;
      leg2_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      step_q   <= step_d;
      target_q <= target_d;
      down_q   <= down_d;
      ready_q  <= ready_d;
`ifdef DDS_SWEEP_TRIANGLE_EN
      start_q  <= start_d;
      tri_q    <= tri_d;
      leg2_q   <= leg2_d;
`endif
    end
  end

  assign K         = k_q;
  assign P         = p_q;
  assign busy      = (state_q == ST_DWELL);
  assign done      = (state_q == ST_FIN);
  assign cfg_ready = ready_q;

endmodule
